table_reader: RTL and testbench

//  Read-side consumer of the precomputed-table FIFO used by the 3072-bit modular-exponentiation datapath.
//  On start, it pulls num_words table entries one at a time through the rinc/rdata/rempty read port.
//  It presents each word to the downstream modular multiplier over a valid/ready handshake.
//  It flags the final word and pulses done when the whole batch has been delivered.

---
 rtl/table_reader_if.sv | 33 +++
 rtl/table_reader.sv | 128 ++++++++++++
 tb/tb_table_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/table_reader_if.sv
// Read-port and operand-port bundle between the table FIFO, table_reader and the modular multiplier.
// master = table_reader side; slave = FIFO/multiplier side.
interface table_reader_if #(
    parameter int WIDTH = 3072
);
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             rempty;
    logic             op_valid;
    logic [WIDTH-1:0] op_data;
    logic             op_ready;
    logic             op_last;

    modport master (
        output rinc,
        input  rdata,
        input  rempty,
        output op_valid,
        output op_data,
        input  op_ready,
        output op_last
    );

    modport slave (
        input  rinc,
        output rdata,
        output rempty,
        input  op_valid,
        input  op_data,
        output op_ready,
        input  op_last
    );
endinterface

// File: rtl/table_reader.sv
// Pops a batch of precomputed table words from the FIFO and hands them one by one to the multiplier.
// Optional stall timeout on an empty FIFO is built when STALL_TIMEOUT_EN is defined.
module table_reader #(
    parameter int WIDTH   = 3072,
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    table_reader_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, REQ, LAT, HOLD, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rem;
    logic             stall_hit;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("table_reader: TIMEOUT must be at least 2");
    end

`ifdef STALL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] stall_cnt;

    assign stall_hit = (state == REQ) && bus.rempty && (stall_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (state == REQ && bus.rempty && !stall_hit)
                stall_cnt <= stall_cnt + 1'b1;
            else
                stall_cnt <= '0;

            if (state == IDLE && start)
                err <= 1'b0;
            else if (stall_hit)
                err <= 1'b1;
        end
    end
`else
    assign stall_hit = 1'b0;
    assign err       = 1'b0;
`endif

    // NOTE: synchronous active-low reset; every register, including the wide op_data, returns to 0.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        bus.rinc  = 1'b0;
        case (state)
            IDLE: if (start && num_words != '0) state_nxt = REQ;
            REQ: begin
                if (stall_hit) begin
                    state_nxt = DONE;
                end else if (!bus.rempty) begin
                    bus.rinc  = 1'b1;
                    state_nxt = LAT;
                end
            end
            LAT:  state_nxt = HOLD;
            HOLD: if (bus.op_ready) state_nxt = (rem == CNT_W'(1)) ? DONE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.op_valid <= 1'b0;
            bus.op_last  <= 1'b0;
            bus.op_data  <= '0;
        end else begin
            // done is high exactly while the FSM sits in DONE, or once after a zero-length start
            done <= (state != DONE) && (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            rem  <= num_words;
                            busy <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                LAT: begin
                    bus.op_data  <= bus.rdata;
                    bus.op_valid <= 1'b1;
                    bus.op_last  <= (rem == CNT_W'(1));
                end
                HOLD: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        bus.op_last  <= 1'b0;
                        // rem stops at 1: the last hand-off leaves via DONE instead
                        if (rem != CNT_W'(1))
                            rem <= rem - 1'b1;
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_table_reader.sv
// Directed bench for table_reader: FIFO model with protocol monitor, hand-stepped expected timing.
module tb_table_reader;
    localparam int WIDTH = 3072;
    localparam int CNT_W = 12;
`ifdef STALL_TIMEOUT_EN
    localparam int TIMEOUT   = 16;
    localparam int STALL_LEN = 12;
`else
    localparam int TIMEOUT   = 1024;
    localparam int STALL_LEN = 20;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             busy;
    logic             done;
    logic             err;

    int tests = 0;
    int fails = 0;

    table_reader_if #(.WIDTH(WIDTH)) bus ();

    table_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears on rdata the cycle after rinc
    logic [WIDTH-1:0] mem [0:15];
    int   rd_ptr     = 0;
    int   wr_ptr     = 0;
    int   pops       = 0;
    int   viol_empty = 0;
    int   viol_b2b   = 0;
    logic rinc_prev  = 1'b0;

    assign bus.rempty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (bus.rinc === 1'b1) begin
            if (bus.rempty) viol_empty++;
            if (rinc_prev) viol_b2b++;
            pops++;
            if (rd_ptr < wr_ptr) begin
                bus.rdata <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        rinc_prev = (bus.rinc === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [7:0] b);
        return {(WIDTH/8){b}};
    endfunction

    task automatic push(input logic [WIDTH-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic check_word(input string tag, input logic [WIDTH-1:0] w, input logic last);
        logic [63:0] lo;
        logic [63:0] hi;
        lo = w[63:0];
        hi = w[WIDTH-1 -: 64];
        check({tag, "_valid"}, 64'(bus.op_valid), 64'd1);
        check({tag, "_lo"}, bus.op_data[63:0], lo);
        check({tag, "_hi"}, bus.op_data[WIDTH-1 -: 64], hi);
        check({tag, "_last"}, 64'(bus.op_last), 64'(last));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && bus.op_valid !== 1'b1; i++) tick();
        check({tag, "_arrive"}, 64'(bus.op_valid), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++) tick();
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        int p0;
        int n;
        bit seen_done;

        bus.op_ready = 1'b1;

        // 1: reset with a non-empty FIFO
        push(mk(8'h5A));
        tick();
        tick();
        check("rst_rinc", 64'(bus.rinc), 64'd0);
        check("rst_valid", 64'(bus.op_valid), 64'd0);
        check("rst_last", 64'(bus.op_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_data", bus.op_data[63:0], 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_rinc", 64'(bus.rinc), 64'd0);
        check("idle_pops", 64'(pops), 64'd0);

        // 2: single word, t = rinc cycle
        start = 1'b1; num_words = 12'd1;
        tick();
        start = 1'b0;
        check("t2_rinc_t", 64'(bus.rinc), 64'd1);
        check("t2_busy", 64'(busy), 64'd1);
        tick();
        check("t2_rinc_t1", 64'(bus.rinc), 64'd0);
        check("t2_valid_t1", 64'(bus.op_valid), 64'd0);
        tick();
        check_word("t2_w", mk(8'h5A), 1'b1);
        tick();
        check("t2_done_t3", 64'(done), 64'd1);
        check("t2_valid_t3", 64'(bus.op_valid), 64'd0);
        tick();
        check("t2_done_end", 64'(done), 64'd0);
        check("t2_busy_end", 64'(busy), 64'd0);
        check("t2_pops", 64'(pops), 64'd1);

        // 3: backpressure on word 2
        push(mk(8'hA1)); push(mk(8'hB2)); push(mk(8'hC3));
        p0 = pops;
        start = 1'b1; num_words = 12'd3;
        tick();
        start = 1'b0;
        wait_valid("t3_w1", 10);
        check_word("t3_w1", mk(8'hA1), 1'b0);
        tick();
        bus.op_ready = 1'b0;
        wait_valid("t3_w2", 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_word("t3_w2_hold", mk(8'hB2), 1'b0);
        end
        bus.op_ready = 1'b1;
        tick();
        check("t3_w2_gone", 64'(bus.op_valid), 64'd0);
        wait_valid("t3_w3", 10);
        check_word("t3_w3", mk(8'hC3), 1'b1);
        tick();
        check("t3_done", 64'(done), 64'd1);
        check("t3_pops", 64'(pops - p0), 64'd3);

        // 4: FIFO empty before word 2
        tick();
        push(mk(8'hD4));
        p0 = pops;
        start = 1'b1; num_words = 12'd2;
        tick();
        start = 1'b0;
        wait_valid("t4_w1", 10);
        check_word("t4_w1", mk(8'hD4), 1'b0);
        tick();
        for (int i = 0; i < STALL_LEN; i++) tick();
        check("t4_stall_busy", 64'(busy), 64'd1);
        check("t4_stall_rinc", 64'(bus.rinc), 64'd0);
        check("t4_stall_valid", 64'(bus.op_valid), 64'd0);
        check("t4_stall_pops", 64'(pops - p0), 64'd1);
        push(mk(8'hE5));
        #1;
        check("t4_rinc", 64'(bus.rinc), 64'd1);
        tick();
        check("t4_lat_valid", 64'(bus.op_valid), 64'd0);
        tick();
        check_word("t4_w2", mk(8'hE5), 1'b1);
        tick();
        check("t4_done", 64'(done), 64'd1);
        check("t4_pops", 64'(pops - p0), 64'd2);

        // 5a: zero-length batch
        tick();
        p0 = pops;
        start = 1'b1; num_words = 12'd0;
        tick();
        start = 1'b0;
        check("t5_zero_done", 64'(done), 64'd1);
        check("t5_zero_busy", 64'(busy), 64'd0);
        tick();
        check("t5_zero_done_end", 64'(done), 64'd0);
        check("t5_zero_pops", 64'(pops - p0), 64'd0);

        // 5b: start while busy and in the DONE cycle are ignored
        push(mk(8'hF6)); push(mk(8'h07));
        start = 1'b1; num_words = 12'd2;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; num_words = 12'd5;
        tick();
        start = 1'b0;
        wait_valid("t5_w1", 10);
        check_word("t5_w1", mk(8'hF6), 1'b0);
        tick();
        wait_valid("t5_w2", 10);
        check_word("t5_w2", mk(8'h07), 1'b1);
        tick();
        check("t5_done", 64'(done), 64'd1);
        start = 1'b1; num_words = 12'd1;
        tick();
        start = 1'b0;
        check("t5_done_start_busy", 64'(busy), 64'd0);
        tick();
        check("t5_done_start_busy2", 64'(busy), 64'd0);
        check("t5_pops", 64'(pops - p0), 64'd2);

        // 5c: reset while holding a word
        push(mk(8'h18));
        bus.op_ready = 1'b0;
        start = 1'b1; num_words = 12'd1;
        tick();
        start = 1'b0;
        wait_valid("t5_hold", 10);
        rst_n = 1'b0;
        tick();
        check("t5_rst_valid", 64'(bus.op_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_last", 64'(bus.op_last), 64'd0);
        rst_n = 1'b1;
        bus.op_ready = 1'b1;
        tick();
        check("t5_rst_idle", 64'(busy), 64'd0);

        // 6: FIFO empty for the whole batch
        p0 = pops;
        start = 1'b1; num_words = 12'd3;
        tick();
        start = 1'b0;
`ifdef STALL_TIMEOUT_EN
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t6_cycles", 64'(n), 64'd16);
        check("t6_done", 64'(done), 64'd1);
        check("t6_err", 64'(err), 64'd1);
        tick();
        check("t6_busy_end", 64'(busy), 64'd0);
        check("t6_err_sticky", 64'(err), 64'd1);
        push(mk(8'h29));
        start = 1'b1; num_words = 12'd1;
        tick();
        start = 1'b0;
        check("t6_err_clr", 64'(err), 64'd0);
        wait_done("t6_next", 10);
        check("t6_pops", 64'(pops - p0), 64'd1);
`else
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_err", 64'(err), 64'd0);
        check("t6_no_done", 64'(seen_done), 64'd0);
        check("t6_pops", 64'(pops - p0), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        check("proto_rinc_empty", 64'(viol_empty), 64'd0);
        check("proto_rinc_b2b", 64'(viol_b2b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
